// File: rtl/mux_4x1_rr_pkg.sv
// Shared definitions for the 4:1 round-robin gather mux and its companion demux.
//   NUM_LANES  : number of input lanes
//   lane_sel_t : encoded lane index carried on out_sel / demux sel
//   lane_inc   : modulo-NUM_LANES increment of a lane index
package mux_4x1_rr_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_sel_t;

  // The 2-bit index wraps naturally, so 3 -> 0 needs no explicit compare.
  function automatic lane_sel_t lane_inc(input lane_sel_t a);
    return a + 2'd1;
  endfunction

endpackage

// File: rtl/mux_4x1_rr_arbiter.sv
// rr_arbiter_4: 4-way round-robin arbiter with a registered priority pointer.
//   clk, rst  : clock, synchronous active-high reset (ptr -> 0)
//   req       : per-lane requests
//   en        : grant is consumed this cycle; ptr advances only on en & |req
//   grant     : one-hot grant (combinational)
//   grant_idx : encoded grant index (equals ptr when nothing is requested)
module rr_arbiter_4
  import mux_4x1_rr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] req,
  input  logic                 en,
  output logic [NUM_LANES-1:0] grant,
  output lane_sel_t            grant_idx
);

  lane_sel_t ptr;

  // Search ptr, ptr+1, ... ; the first requester found wins.
  always_comb begin
    lane_sel_t idx;
    logic      found;
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    idx       = ptr;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = ptr + lane_sel_t'(k);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Granted lane drops to lowest priority for the next search.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (en && |req)
      ptr <= lane_inc(grant_idx);
  end

endmodule

// File: rtl/mux_4x1_rr.sv
// mux_4x1_rr: gathers 4 valid/ready lanes into one registered output slot,
// choosing lanes round-robin and tagging each word with its source lane.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : per-lane data, index = lane number
//   in_valid   : per-lane valid
//   in_ready   : per-lane ready, at most one bit set
//   out_data   : registered output word
//   out_sel    : lane the output word came from
//   out_valid  : output slot holds a word
//   out_ready  : consumer takes the word this cycle
module mux_4x1_rr
  import mux_4x1_rr_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES-1:0][WIDTH-1:0] in_data,
  input  logic [NUM_LANES-1:0]            in_valid,
  output logic [NUM_LANES-1:0]            in_ready,
  output logic [WIDTH-1:0]                out_data,
  output lane_sel_t                       out_sel,
  output logic                            out_valid,
  input  logic                            out_ready
);

  logic [NUM_LANES-1:0] grant;
  lane_sel_t            grant_idx;
  logic                 slot_free;
  logic                 in_xfer;

  // Draining slot can be refilled in the same cycle -> 1 word/cycle.
  assign slot_free = ~out_valid | out_ready;

  rr_arbiter_4 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .en        (slot_free),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Nothing is accepted during reset; the word would be dropped anyway.
  assign in_ready = grant & {NUM_LANES{slot_free & ~rst}};
  assign in_xfer  = |in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx];
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      // Drained with no refill: data/sel keep their last values.
      out_valid <= 1'b0;
    end
  end

endmodule
